radar_trig_conditioner: RTL

RADAR_TRIG_CONDITIONER -- requirements
Module: radar_trig_conditioner

---
 rtl/radar_trig_conditioner_if.sv | 37 +++
 rtl/radar_trig_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/radar_trig_conditioner_if.sv
// Trigger conditioner bus: enable and raw trigger in, conditioned pulses,
// timing measurements and counters out.
interface radar_trig_conditioner_if;
    logic        en;
    logic        radar_trig;
    logic        radar_trig_pe;
    logic        usec_pe;
    logic [31:0] trig_period_us;
    logic        trig_period_valid;
    logic        trig_timeout;
    logic [31:0] trig_count;
    logic [15:0] trig_reject_count;

    modport master (
        output en,
        output radar_trig,
        input  radar_trig_pe,
        input  usec_pe,
        input  trig_period_us,
        input  trig_period_valid,
        input  trig_timeout,
        input  trig_count,
        input  trig_reject_count
    );

    modport slave (
        input  en,
        input  radar_trig,
        output radar_trig_pe,
        output usec_pe,
        output trig_period_us,
        output trig_period_valid,
        output trig_timeout,
        output trig_count,
        output trig_reject_count
    );
endinterface

// File: rtl/radar_trig_conditioner.sv
// Radar trigger conditioner: synchronises the raw trigger, blanks re-triggers,
// phase-locks a microsecond tick to accepted triggers and measures their period.
module radar_trig_conditioner #(
    parameter int unsigned USEC_DIV      = 100,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned MIN_PERIOD_US = 100,
    parameter int unsigned TIMEOUT_US    = 10000
) (
    input logic                     sys_clk,
    input logic                     rst,
    radar_trig_conditioner_if.slave bus
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned PW     = (USEC_DIV > 1) ? $clog2(USEC_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ARMED,
        LOST
    } state_t;

    state_t        state;
    logic [STAGES-1:0] sync_q;
    logic          prev;
    logic          rise;
    logic [PW-1:0] presc;
    logic [31:0]   us_since;

    logic          pe_q;
    logic          usec_q;
    logic [31:0]   period_q;
    logic          valid_q;
    logic          timeout_q;
    logic [31:0]   count_q;
    logic [15:0]   reject_q;

    logic          wrap;
    logic [31:0]   us_next;
    logic          accept;
    logic          reject;

    // The synchroniser and prev keep running through reset and disable so a
    // trigger that is already high never looks like a fresh edge.
    always_ff @(posedge sys_clk) begin
        sync_q <= {sync_q[STAGES-2:0], bus.radar_trig};
        prev   <= sync_q[STAGES-1];
        if (rst) begin
            rise <= 1'b0;
        end else begin
            rise <= sync_q[STAGES-1] & ~prev;
        end
    end

    always_comb begin
        wrap    = (presc == PW'(USEC_DIV - 1));
        us_next = us_since;
        if (wrap && (us_since != 32'hFFFF_FFFF)) begin
            us_next = us_since + 32'd1;
        end
        accept  = rise && (state != BLANK);
        reject  = rise && (state == BLANK);
    end

    // us_next already includes a wrap landing on the trigger cycle, which is
    // exactly floor(cycles between pulses / USEC_DIV).
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            us_since  <= '0;
            pe_q      <= 1'b0;
            usec_q    <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            reject_q  <= '0;
        end else if (!bus.en) begin
            state     <= IDLE;
            presc     <= '0;
            us_since  <= '0;
            pe_q      <= 1'b0;
            usec_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            if (state == ARMED) begin
                period_q <= us_next;
                valid_q  <= 1'b1;
            end
            state     <= BLANK;
            presc     <= '0;
            us_since  <= '0;
            pe_q      <= 1'b1;
            usec_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= count_q + 32'd1;
        end else begin
            presc    <= wrap ? '0 : presc + 1'b1;
            usec_q   <= wrap;
            us_since <= us_next;
            pe_q     <= 1'b0;
            if (reject && (reject_q != 16'hFFFF)) begin
                reject_q <= reject_q + 16'd1;
            end
            case (state)
                BLANK: begin
                    if (us_next >= 32'(MIN_PERIOD_US)) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (us_next >= 32'(TIMEOUT_US)) begin
                        state     <= LOST;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.radar_trig_pe     = pe_q;
    assign bus.usec_pe           = usec_q;
    assign bus.trig_period_us    = period_q;
    assign bus.trig_period_valid = valid_q;
    assign bus.trig_timeout      = timeout_q;
    assign bus.trig_count        = count_q;
    assign bus.trig_reject_count = reject_q;

endmodule
